// File: rtl/run_controller.sv
// Bring-up run controller: sequences CPU reset, counts cycles/retires,
// captures the first TRACE_DEPTH commits and decides pass/fail on halt or timeout.
//
// state  | meaning
// S_HOLD | CPU held in reset while the hold counter runs
// S_RUN  | CPU running; counters, trace and shadows update
// S_DONE | run ended by halt or timeout; CPU frozen, everything holds
module run_controller #(
  parameter int              XLEN        = 32,
  parameter int              RST_CYCLES  = 10,
  parameter int              TRACE_DEPTH = 16,
  parameter int              MAX_CYCLES  = 10000,
  parameter logic [31:0]     HALT_INST   = 32'h00000073,
  parameter logic [XLEN-1:0] PASS_VALUE  = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         cpu_rst_o,
  input  logic                         commit_valid_i,
  input  logic [XLEN-1:0]              commit_pc_i,
  input  logic [31:0]                  commit_inst_i,
  input  logic                         wb_en_i,
  input  logic [4:0]                   wb_addr_i,
  input  logic [XLEN-1:0]              wb_data_i,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_raddr_i,
  output logic [XLEN-1:0]              trace_pc_o,
  output logic [31:0]                  trace_inst_o,
  output logic [$clog2(TRACE_DEPTH):0] trace_count_o,
  output logic [31:0]                  cycle_count_o,
  output logic [31:0]                  retire_count_o,
  output logic [XLEN-1:0]              ra_value_o,
  output logic [XLEN-1:0]              a0_value_o,
  output logic                         done_o,
  output logic                         timeout_o,
  output logic                         pass_o
);

  localparam int              AW        = $clog2(TRACE_DEPTH);
  localparam int              HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [31:0]     CYC_LAST  = 32'(MAX_CYCLES - 1);
  localparam logic [AW:0]     DEPTH     = (AW+1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       retire_q, retire_d;
  logic [AW:0]       tcount_q, tcount_d;
  logic [XLEN-1:0]   ra_q, ra_d;
  logic [XLEN-1:0]   a0_q, a0_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;
  logic              trace_we;
  logic              halt;
  logic [XLEN-1:0]   a0_fwd;

  logic [XLEN-1:0]   pc_mem   [TRACE_DEPTH];
  logic [31:0]       inst_mem [TRACE_DEPTH];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    tcount_d   = tcount_q;
    ra_d       = ra_q;
    a0_d       = a0_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    trace_we   = 1'b0;
    halt       = commit_valid_i && (commit_inst_i == HALT_INST);
    // pass compare must see a writeback to x10 landing in the halt cycle
    a0_fwd     = (wb_en_i && wb_addr_i == 5'd10) ? wb_data_i : a0_q;

    case (state_q)
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
        if (commit_valid_i) begin
          if (retire_q != '1) retire_d = retire_q + 32'd1;
          if (tcount_q < DEPTH) begin
            trace_we = 1'b1;
            tcount_d = tcount_q + (AW+1)'(1);
          end
        end
        if (wb_en_i && wb_addr_i == 5'd1)  ra_d = wb_data_i;
        if (wb_en_i && wb_addr_i == 5'd10) a0_d = wb_data_i;
        if (halt) begin
          state_d = S_DONE;
          pass_d  = (a0_fwd == PASS_VALUE);
        end else if (cycle_q == CYC_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      cycle_q    <= '0;
      retire_q   <= '0;
      tcount_q   <= '0;
      ra_q       <= '0;
      a0_q       <= '0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
      tcount_q   <= tcount_d;
      ra_q       <= ra_d;
      a0_q       <= a0_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
    end
  end

  // Trace storage carries no reset; tcount_q alone defines which entries are valid.
  always_ff @(posedge clk_i) begin
    if (trace_we && !rst_i) begin
      pc_mem[tcount_q[AW-1:0]]   <= commit_pc_i;
      inst_mem[tcount_q[AW-1:0]] <= commit_inst_i;
    end
  end

  assign trace_pc_o     = pc_mem[trace_raddr_i];
  assign trace_inst_o   = inst_mem[trace_raddr_i];
  assign trace_count_o  = tcount_q;
  assign cycle_count_o  = cycle_q;
  assign retire_count_o = retire_q;
  assign ra_value_o     = ra_q;
  assign a0_value_o     = a0_q;
  assign cpu_rst_o      = (state_q != S_RUN);
  assign done_o         = (state_q == S_DONE);
  assign timeout_o      = timeout_q;
  assign pass_o         = pass_q;

endmodule

// File: tb/tb_run_controller.sv
// Testbench for run_controller: hand-written vectors and sequences plus random
// stimulus compared every cycle against a behavioural model of the run rules.
module tb_run_controller;

  localparam int          XLEN   = 32;
  localparam int          RSTC   = 10;
  localparam int          DEPTH  = 16;
  localparam int          MAXC   = 100;
  localparam logic [31:0] HALT   = 32'h00000073;
  localparam logic [31:0] PASSV  = 32'd0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_rst_o;
  logic        commit_valid_i;
  logic [31:0] commit_pc_i;
  logic [31:0] commit_inst_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [3:0]  trace_raddr_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_inst_o;
  logic [4:0]  trace_count_o;
  logic [31:0] cycle_count_o;
  logic [31:0] retire_count_o;
  logic [31:0] ra_value_o;
  logic [31:0] a0_value_o;
  logic        done_o;
  logic        timeout_o;
  logic        pass_o;

  run_controller #(
    .XLEN(XLEN), .RST_CYCLES(RSTC), .TRACE_DEPTH(DEPTH), .MAX_CYCLES(MAXC),
    .HALT_INST(HALT), .PASS_VALUE(PASSV)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_rst_o(cpu_rst_o),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_inst_i(commit_inst_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .trace_raddr_i(trace_raddr_i),
    .trace_pc_o(trace_pc_o), .trace_inst_o(trace_inst_o),
    .trace_count_o(trace_count_o), .cycle_count_o(cycle_count_o),
    .retire_count_o(retire_count_o), .ra_value_o(ra_value_o),
    .a0_value_o(a0_value_o), .done_o(done_o), .timeout_o(timeout_o),
    .pass_o(pass_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model: run phase as flags, trace as queues.
  int          m_hold;
  bit          m_run, m_done, m_timeout, m_pass;
  logic [31:0] m_cyc, m_ret, m_ra, m_a0;
  logic [31:0] m_tpc[$];
  logic [31:0] m_tinst[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit halt;
    if (rst_i) begin
      m_hold = 0; m_run = 0; m_done = 0; m_timeout = 0; m_pass = 0;
      m_cyc = 0; m_ret = 0; m_ra = 0; m_a0 = 0;
      m_tpc.delete(); m_tinst.delete();
    end else if (m_done) begin
    end else if (!m_run) begin
      m_hold++;
      if (m_hold == RSTC) m_run = 1;
    end else begin
      halt = commit_valid_i && (commit_inst_i == HALT);
      if (m_cyc != 32'hFFFFFFFF) m_cyc++;
      if (commit_valid_i) begin
        if (m_ret != 32'hFFFFFFFF) m_ret++;
        if (m_tpc.size() < DEPTH) begin
          m_tpc.push_back(commit_pc_i);
          m_tinst.push_back(commit_inst_i);
        end
      end
      if (wb_en_i && wb_addr_i == 5'd1)  m_ra = wb_data_i;
      if (wb_en_i && wb_addr_i == 5'd10) m_a0 = wb_data_i;
      if (halt) begin
        m_done = 1; m_run = 0; m_pass = (m_a0 == PASSV);
      end else if (m_cyc == MAXC) begin
        m_done = 1; m_run = 0; m_timeout = 1;
      end
    end
  endtask

  task automatic compare_model();
    int idx;
    check("cpu_rst", cpu_rst_o, !m_run);
    check("done", done_o, m_done);
    check("timeout", timeout_o, m_timeout);
    check("pass", pass_o, m_pass);
    check("cycle_count", cycle_count_o, m_cyc);
    check("retire_count", retire_count_o, m_ret);
    check("ra_value", ra_value_o, m_ra);
    check("a0_value", a0_value_o, m_a0);
    check("trace_count", trace_count_o, m_tpc.size());
    if (m_tpc.size() > 0) begin
      idx = $urandom_range(0, m_tpc.size() - 1);
      trace_raddr_i = idx[3:0];
      #1;
      check("trace_pc", trace_pc_o, m_tpc[idx]);
      check("trace_inst", trace_inst_o, m_tinst[idx]);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle();
    commit_valid_i = 0; commit_pc_i = 0; commit_inst_i = 32'h00000013;
    wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
  endtask

  task automatic go_run();
    int n;
    idle();
    rst_i = 1;
    step(); step();
    rst_i = 0;
    n = 0;
    while (cpu_rst_o && n < 50) begin
      step();
      n++;
    end
    check("hold_edges", n, RSTC);
  endtask

  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wb;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] e_ra;
    logic [31:0] e_a0;
    logic [31:0] e_ret;
    int          e_tc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{0, 0,      32'h13, 1, 5'd0,  32'd7,        32'h0,        32'h0, 0, 0};
    vecs[1] = '{0, 0,      32'h13, 1, 5'd1,  32'h1234,     32'h1234,     32'h0, 0, 0};
    vecs[2] = '{1, 32'd100, 32'h13, 1, 5'd10, 32'd5,       32'h1234,     32'd5, 1, 1};
    vecs[3] = '{0, 0,      32'h13, 1, 5'd2,  32'd99,       32'h1234,     32'd5, 1, 1};
    vecs[4] = '{1, 32'd104, 32'h33, 0, 5'd1,  32'd42,      32'h1234,     32'd5, 2, 2};
    vecs[5] = '{1, 32'd108, 32'h93, 1, 5'd1,  32'hDEADBEEF, 32'hDEADBEEF, 32'd5, 3, 3};
    vecs[6] = '{0, 0,      32'h13, 0, 5'd10, 32'd77,       32'hDEADBEEF, 32'd5, 3, 3};
    vecs[7] = '{0, 0,      32'h13, 1, 5'd0,  32'hFFFFFFFF, 32'hDEADBEEF, 32'd5, 3, 3};

    idle();
    trace_raddr_i = 0;
    rst_i = 1;
    repeat (3) step();
    check("rst_cpu_rst", cpu_rst_o, 1);
    check("rst_trace_count", trace_count_o, 0);

    // Reset release: cpu_rst stays high for exactly RST_CYCLES cycles
    rst_i = 0;
    n = 0;
    while (cpu_rst_o && n < 50) begin
      check("hold_done", done_o, 0);
      check("hold_cycle", cycle_count_o, 0);
      step();
      n++;
    end
    check("rst_release_cycles", n, RSTC);

    // Table vectors: shadow writes and commits
    for (int i = 0; i < 8; i++) begin
      commit_valid_i = vecs[i].cv; commit_pc_i = vecs[i].pc; commit_inst_i = vecs[i].inst;
      wb_en_i = vecs[i].wb; wb_addr_i = vecs[i].addr; wb_data_i = vecs[i].data;
      step();
      check($sformatf("vec%0d_ra", i), ra_value_o, vecs[i].e_ra);
      check($sformatf("vec%0d_a0", i), a0_value_o, vecs[i].e_a0);
      check($sformatf("vec%0d_retire", i), retire_count_o, vecs[i].e_ret);
      check($sformatf("vec%0d_tcount", i), trace_count_o, vecs[i].e_tc);
    end
    idle();

    // Reset mid-run
    rst_i = 1;
    step();
    check("midrst_ra", ra_value_o, 0);
    check("midrst_tcount", trace_count_o, 0);
    check("midrst_cpu_rst", cpu_rst_o, 1);
    rst_i = 0;

    // Trace capture: first 16 of 20 commits kept
    go_run();
    for (int i = 0; i < 20; i++) begin
      commit_valid_i = 1; commit_pc_i = 4 * i; commit_inst_i = 32'h00100013 + (i << 20);
      step();
    end
    idle();
    check("trace_full_count", trace_count_o, 16);
    check("trace_retire20", retire_count_o, 20);
    for (int k = 0; k < DEPTH; k++) begin
      trace_raddr_i = k[3:0];
      #1;
      check($sformatf("trace_pc%0d", k), trace_pc_o, 4 * k);
    end

    // Halt with a0 == 0 -> pass
    go_run();
    wb_en_i = 1; wb_addr_i = 10; wb_data_i = 0;
    step();
    idle();
    commit_valid_i = 1; commit_inst_i = HALT; commit_pc_i = 32'h200;
    step();
    idle();
    check("halt_done", done_o, 1);
    check("halt_pass", pass_o, 1);
    check("halt_timeout", timeout_o, 0);
    check("halt_cpu_rst", cpu_rst_o, 1);
    commit_valid_i = 1; wb_en_i = 1; wb_addr_i = 1; wb_data_i = 32'h55;
    repeat (3) step();
    idle();
    check("done_hold_retire", retire_count_o, 1);
    check("done_hold_ra", ra_value_o, 0);

    // Halt with same-cycle a0 writeback of 5 -> fail
    go_run();
    commit_valid_i = 1; commit_inst_i = HALT;
    wb_en_i = 1; wb_addr_i = 10; wb_data_i = 5;
    step();
    idle();
    check("fwd_done", done_o, 1);
    check("fwd_pass", pass_o, 0);
    check("fwd_a0", a0_value_o, 5);

    // Timeout after MAXC run cycles
    go_run();
    n = 0;
    while (!done_o && n < 200) begin
      step();
      n++;
    end
    check("to_run_cycles", n, MAXC);
    check("to_timeout", timeout_o, 1);
    check("to_pass", pass_o, 0);
    check("to_cycle_count", cycle_count_o, MAXC);
    repeat (3) step();
    check("to_cycle_hold", cycle_count_o, MAXC);

    // Halt on the last permitted run cycle: halt wins
    go_run();
    repeat (MAXC - 1) step();
    check("h99_cycle", cycle_count_o, MAXC - 1);
    check("h99_not_done", done_o, 0);
    commit_valid_i = 1; commit_inst_i = HALT;
    step();
    idle();
    check("h99_done", done_o, 1);
    check("h99_timeout", timeout_o, 0);
    check("h99_pass", pass_o, 1);

    // Random stimulus against the model
    for (int r = 0; r < 6; r++) begin
      go_run();
      for (int c = 0; c < 150; c++) begin
        rst_i = ($urandom_range(0, 79) == 0);
        commit_valid_i = ($urandom_range(0, 9) < 6);
        commit_pc_i = $urandom;
        commit_inst_i = ($urandom_range(0, 24) == 0) ? HALT : $urandom;
        wb_en_i = $urandom_range(0, 1);
        case ($urandom_range(0, 3))
          0: wb_addr_i = 5'd0;
          1: wb_addr_i = 5'd1;
          2: wb_addr_i = 5'd10;
          default: wb_addr_i = 5'($urandom_range(0, 31));
        endcase
        case ($urandom_range(0, 2))
          0: wb_data_i = PASSV;
          1: wb_data_i = 32'd5;
          default: wb_data_i = $urandom;
        endcase
        step();
      end
      rst_i = 0;
      idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/run_controller.md
# run_controller

Parametrised run controller that sits beside `cpu_top` in simulation and FPGA bring-up builds. It sequences CPU reset, counts cycles and retired instructions, and captures the first `TRACE_DEPTH` commits into a readable trace buffer. It also detects program end on a halt instruction or a cycle timeout, and keeps shadow copies of `ra` (x1) and `a0` (x10) so pass/fail is decided in hardware.

## Interface
Parameters:
- `XLEN`, 32: datapath width of PC and register data.
- `RST_CYCLES`, 10: cycles `cpu_rst` stays high after `rst` deasserts; must be ≥1.
- `TRACE_DEPTH`, 16: trace entries; power of two, ≥2.
- `MAX_CYCLES`, 10000: RUN cycles before timeout; ≥1.
- `HALT_INST`, 32'h00000073 (`ecall`): committed instruction that ends the run.
- `PASS_VALUE`, 0: `a0` value that signals pass.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_rst` out 1: reset to `cpu_top`.
- `commit_valid` in 1: one instruction retires this cycle.
- `commit_pc` in XLEN: PC of the retiring instruction.
- `commit_inst` in 32: encoding of the retiring instruction.
- `wb_en` in 1: register write this cycle.
- `wb_addr` in 5: destination register.
- `wb_data` in XLEN: write data.
- `trace_raddr` in log2(TRACE_DEPTH): trace read index.
- `trace_pc` out XLEN: PC at `trace_raddr`, combinational read.
- `trace_inst` out 32: instruction at `trace_raddr`, combinational read.
- `trace_count` out log2(TRACE_DEPTH)+1: valid trace entries.
- `cycle_count` out 32: cycles spent in RUN.
- `retire_count` out 32: commits seen in RUN.
- `ra_value` out XLEN: shadow of x1.
- `a0_value` out XLEN: shadow of x10.
- `done` out 1: run finished, by halt or timeout.
- `timeout` out 1: run ended by `MAX_CYCLES`.
- `pass` out 1: halted with `a0_value == PASS_VALUE`.

## Operation
- States: HOLD, RUN, DONE.
- While `rst` is high, the next state is HOLD, the hold counter is 0, and all outputs are at reset values.
- Reset values:
  - `cpu_rst` is 1.
  - All counters, `trace_count`, `ra_value` and `a0_value` are 0.
  - `done`, `timeout` and `pass` are 0.
  - Trace storage contents are don't-care.
- HOLD:
  - `cpu_rst` is 1.
  - The hold counter increments each cycle.
  - When the counter reaches `RST_CYCLES-1`, the next state is RUN.
  - Commit and writeback inputs are ignored.
- RUN:
  - `cpu_rst` is 0.
  - `cycle_count` increments every cycle.
  - `retire_count` increments on each cycle with `commit_valid`.
  - If `commit_valid` is high and `trace_count < TRACE_DEPTH`, write {`commit_pc`, `commit_inst`} to entry `trace_count`, then increment `trace_count`.
  - Once `trace_count` reaches `TRACE_DEPTH`, further commits are not recorded. There is no wrap-around; the buffer keeps the first commits.
  - `wb_en` with `wb_addr==1` updates `ra_value`.
  - `wb_en` with `wb_addr==10` updates `a0_value`.
  - Writes to x0 and all other addresses are ignored.
- Halt: `commit_valid` with `commit_inst == HALT_INST` causes:
  - next state DONE and `done` = 1;
  - `pass` = (a0 after this cycle's writeback == `PASS_VALUE`). A same-cycle writeback to x10 is forwarded into this compare.
- Timeout: when `cycle_count` reaches `MAX_CYCLES-1` and this cycle is not a halt:
  - next state DONE;
  - `done` = 1, `timeout` = 1, `pass` = 0.
- Halt and timeout in the same cycle: halt wins, so `timeout` = 0.
- The halting commit is counted in `retire_count` and recorded in trace if space remains.
- DONE:
  - `cpu_rst` is 1, which freezes the CPU.
  - All counters, shadows, trace contents and flags hold.
  - Only `rst` leaves DONE.
- Counters saturate at 32'hFFFFFFFF and do not wrap.

## Timing
- `cpu_rst` falls exactly `RST_CYCLES` rising edges after the first edge that samples `rst` = 0.
- Commit and writeback inputs are sampled on the rising edge. Updated counters, shadows and trace are visible the following cycle.
- `done`, `timeout` and `pass` assert on the cycle after the halt commit or the final RUN cycle.
- `cpu_rst` returns to 1 on that same edge.
- `rst` asserted mid-RUN or in DONE: on the next edge, all state returns to reset values and HOLD restarts. The trace is logically emptied (`trace_count` = 0).
- Trace read is combinational from `trace_raddr`. Reading an index ≥ `trace_count` returns don't-care data.

## Test plan
- Reset sequencing: `rst` high for 3 cycles, then low, with `RST_CYCLES`=10 → `cpu_rst` is 1 for exactly 10 cycles after release, then 0; all outputs are 0 during HOLD.
- Trace capture: 20 commits with pc = 0, 4, 8, …, `TRACE_DEPTH`=16 →
  - `trace_count` = 16;
  - entry 15 has pc 60;
  - `retire_count` = 20.
- Halt pass: writeback x10 = 0, then commit 32'h00000073 → `done` = 1, `pass` = 1, `timeout` = 0 one cycle later; `cpu_rst` = 1.
- Same-cycle halt with writeback: halt commit in the same cycle as `wb_en` x10 = 5 → `pass` = 0, `a0_value` = 5.
- Timeout: `MAX_CYCLES`=100 with no halt → `done` = 1 and `timeout` = 1 after 100 RUN cycles; `cycle_count` = 100 and holds. Also test halt on cycle 99 → `timeout` = 0.
- Reset mid-run plus x0/x1 writes:
  - write x0 = 7 → shadows unchanged;
  - write x1 = 32'h1234 → `ra_value` = 32'h1234;
  - assert `rst` mid-RUN → the next cycle, `ra_value` = 0, `trace_count` = 0, state is HOLD.
